// File: rtl/store_mon_pkg.sv
// store_mon_pkg: shared state/classification encodings and default check constants
// for the store result monitor.
`default_nettype none

package store_mon_pkg;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    PASS    = 2'd1,
    FAIL    = 2'd2,
    TIMEOUT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    OK   = 2'd1,
    SIG  = 2'd2,
    BAD  = 2'd3
  } cls_e;

  localparam logic [31:0] DEF_PASS_ADDR = 32'd44;
  localparam logic [31:0] DEF_PASS_DATA = 32'hFFFF_FFFD;
  localparam logic [31:0] DEF_WIN_LO    = 32'd96;
  localparam logic [31:0] DEF_WIN_HI    = 32'd96;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/store_mon_classify.sv
// store_mon_classify: combinational classifier for one store port
// (NONE / OK / SIG / BAD).
`default_nettype none

module store_mon_classify
  import store_mon_pkg::*;
#(
  parameter int                 ADDR_W    = 32,
  parameter int                 DATA_W    = 32,
  parameter logic [ADDR_W-1:0]  PASS_ADDR = ADDR_W'(DEF_PASS_ADDR),
  parameter logic [DATA_W-1:0]  PASS_DATA = DATA_W'(DEF_PASS_DATA),
  parameter logic [ADDR_W-1:0]  WIN_LO    = ADDR_W'(DEF_WIN_LO),
  parameter logic [ADDR_W-1:0]  WIN_HI    = ADDR_W'(DEF_WIN_HI)
) (
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic [DATA_W-1:0] data_i,
  output cls_e              cls_o
);

  // An unknown strobe falls into the default arm and is reported as BAD.
  // The signature address is checked first so a wrong value there is BAD
  // even when the address also lies inside the window.
  always_comb begin
    cls_o = NONE;
    case (valid_i)
      1'b0: cls_o = NONE;
      1'b1: begin
        if (adr_i == PASS_ADDR) begin
          cls_o = (data_i == PASS_DATA) ? SIG : BAD;
        end else if (adr_i >= WIN_LO && adr_i <= WIN_HI) begin
          cls_o = OK;
        end else begin
          cls_o = BAD;
        end
      end
      default: cls_o = BAD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/store_result_monitor.sv
// store_result_monitor: N-port store watcher latching a sticky PASS/FAIL/TIMEOUT verdict.
// Optional STORE_MON_REPORT_EN adds simulation messages and a $stop after the verdict.
`default_nettype none

module store_result_monitor
  import store_mon_pkg::*;
#(
  parameter int                 NPORT       = 1,
  parameter int                 ADDR_W      = 32,
  parameter int                 DATA_W      = 32,
  parameter logic [ADDR_W-1:0]  PASS_ADDR   = ADDR_W'(DEF_PASS_ADDR),
  parameter logic [DATA_W-1:0]  PASS_DATA   = DATA_W'(DEF_PASS_DATA),
  parameter logic [ADDR_W-1:0]  WIN_LO      = ADDR_W'(DEF_WIN_LO),
  parameter logic [ADDR_W-1:0]  WIN_HI      = ADDR_W'(DEF_WIN_HI),
  parameter int                 TIMEOUT_CYC = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NPORT-1:0]        mem_write,
  input  logic [NPORT*ADDR_W-1:0] data_adr,
  input  logic [NPORT*DATA_W-1:0] write_data,
  output logic                    done,
  output logic                    pass,
  output logic                    fail,
  output logic                    timeout,
  output logic [1:0]              fail_port,
  output logic [ADDR_W-1:0]       fail_adr,
  output logic [DATA_W-1:0]       fail_data,
  output logic [15:0]             store_count,
  output logic [31:0]             cycle_count
);

  localparam logic [31:0] LAST_CYC = 32'(TIMEOUT_CYC - 1);

  cls_e cls [NPORT];

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
    store_mon_classify #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .PASS_ADDR (PASS_ADDR),
      .PASS_DATA (PASS_DATA),
      .WIN_LO    (WIN_LO),
      .WIN_HI    (WIN_HI)
    ) u_cls (
      .valid_i (mem_write[gi]),
      .adr_i   (data_adr[gi*ADDR_W +: ADDR_W]),
      .data_i  (write_data[gi*DATA_W +: DATA_W]),
      .cls_o   (cls[gi])
    );
  end

  state_e              state_q, state_d;
  logic [15:0]         store_cnt_q, store_cnt_d;
  logic [31:0]         cyc_q, cyc_d;
  logic [1:0]          fail_port_q, fail_port_d;
  logic [ADDR_W-1:0]   fail_adr_q, fail_adr_d;
  logic [DATA_W-1:0]   fail_data_q, fail_data_d;

  logic                hit, hit_sig;
  logic [1:0]          hit_idx;
  logic [ADDR_W-1:0]   hit_adr;
  logic [DATA_W-1:0]   hit_data;
  logic [16:0]         store_sum;

  // Scan high to low so the lowest-index deciding port wins.
  always_comb begin
    hit      = 1'b0;
    hit_sig  = 1'b0;
    hit_idx  = 2'd0;
    hit_adr  = '0;
    hit_data = '0;
    for (int i = NPORT - 1; i >= 0; i--) begin
      if (cls[i] == SIG || cls[i] == BAD) begin
        hit      = 1'b1;
        hit_sig  = (cls[i] == SIG);
        hit_idx  = 2'(i);
        hit_adr  = data_adr[i*ADDR_W +: ADDR_W];
        hit_data = write_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign store_sum = {1'b0, store_cnt_q} + 17'(popcount4(4'(mem_write)));

  always_comb begin
    state_d     = state_q;
    store_cnt_d = store_cnt_q;
    cyc_d       = cyc_q;
    fail_port_d = fail_port_q;
    fail_adr_d  = fail_adr_q;
    fail_data_d = fail_data_q;
    if (state_q == ARMED) begin
      store_cnt_d = store_sum[16] ? 16'hFFFF : store_sum[15:0];
      if (hit) begin
        state_d = hit_sig ? PASS : FAIL;
        if (!hit_sig) begin
          fail_port_d = hit_idx;
          fail_adr_d  = hit_adr;
          fail_data_d = hit_data;
        end
      end else if (cyc_q == LAST_CYC) begin
        state_d = TIMEOUT;
      end else begin
        cyc_d = cyc_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARMED;
      store_cnt_q <= '0;
      cyc_q       <= '0;
      fail_port_q <= '0;
      fail_adr_q  <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      store_cnt_q <= store_cnt_d;
      cyc_q       <= cyc_d;
      fail_port_q <= fail_port_d;
      fail_adr_q  <= fail_adr_d;
      fail_data_q <= fail_data_d;
    end
  end

  assign done        = (state_q != ARMED);
  assign pass        = (state_q == PASS);
  assign fail        = (state_q == FAIL);
  assign timeout     = (state_q == TIMEOUT);
  assign fail_port   = fail_port_q;
  assign fail_adr    = fail_adr_q;
  assign fail_data   = fail_data_q;
  assign store_count = store_cnt_q;
  assign cycle_count = cyc_q;

`ifdef STORE_MON_REPORT_EN
  logic done_seen_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      done_seen_q <= 1'b0;
    end else begin
      done_seen_q <= done;
      if (state_q == ARMED && state_d == PASS)
        $display("Simulation succeeded after %0d cycles", cyc_q);
      if (state_q == ARMED && state_d == FAIL)
        $display("Simulation failed: port %0d addr %0h data %0h", hit_idx, hit_adr, hit_data);
      if (state_q == ARMED && state_d == TIMEOUT)
        $display("Simulation timeout after %0d cycles", cyc_q);
      if (done && !done_seen_q)
        $stop;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_store_result_monitor.sv
// tb_store_result_monitor: scoreboard bench for store_result_monitor (NPORT=2, TIMEOUT_CYC=20).
`default_nettype none

module tb_store_result_monitor;

  localparam int          TO = 20;
  localparam logic [31:0] PA = 32'd44;
  localparam logic [31:0] PD = 32'hFFFF_FFFD;
  localparam logic [31:0] WL = 32'd96;
  localparam logic [31:0] WH = 32'd96;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_write;
  logic [63:0] data_adr, write_data;
  logic        done, pass, fail, timeout;
  logic [1:0]  fail_port;
  logic [31:0] fail_adr, fail_data, cycle_count;
  logic [15:0] store_count;
  logic [117:0] obs;

  store_result_monitor #(
    .NPORT       (2),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_write   (mem_write),
    .data_adr    (data_adr),
    .write_data  (write_data),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout),
    .fail_port   (fail_port),
    .fail_adr    (fail_adr),
    .fail_data   (fail_data),
    .store_count (store_count),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  assign obs = {done, pass, fail, timeout, fail_port, fail_adr, fail_data, store_count, cycle_count};

  int checks = 0;
  int errors = 0;
  logic [117:0] expq[$];
  logic [117:0] obsq[$];

  // Reference model: 0=armed 1=pass 2=fail 3=timeout
  int          m_st;
  logic [15:0] m_sc;
  logic [31:0] m_cc, m_fa, m_fd;
  logic [1:0]  m_fp;

  function automatic logic [117:0] pack_model();
    return {m_st != 0, m_st == 1, m_st == 2, m_st == 3, m_fp, m_fa, m_fd, m_sc, m_cc};
  endfunction

  task automatic model_step(input logic rst, input logic [1:0] we,
                            input logic [31:0] a0, d0, a1, d1);
    int verdict;
    int cnt;
    logic [31:0] a [2];
    logic [31:0] d [2];
    a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
    if (rst) begin
      m_st = 0; m_sc = '0; m_cc = '0; m_fp = '0; m_fa = '0; m_fd = '0;
    end else if (m_st == 0) begin
      verdict = 0;
      for (int p = 0; p < 2; p++) begin
        if (we[p] && verdict == 0) begin
          if (a[p] == PA && d[p] == PD) verdict = 1;
          else if (a[p] == PA || a[p] < WL || a[p] > WH) begin
            verdict = 2; m_fp = 2'(p); m_fa = a[p]; m_fd = d[p];
          end
        end
      end
      cnt = int'(m_sc) + int'(we[0]) + int'(we[1]);
      m_sc = (cnt > 65535) ? 16'hFFFF : 16'(cnt);
      if (verdict != 0) m_st = verdict;
      else if (m_cc == 32'(TO - 1)) m_st = 3;
      else m_cc = m_cc + 32'd1;
    end
  endtask

  task automatic cycle(input logic rst, input logic [1:0] we,
                       input logic [31:0] a0, d0, a1, d1);
    reset      = rst;
    mem_write  = we;
    data_adr   = {a1, a0};
    write_data = {d1, d0};
    model_step(rst, we, a0, d0, a1, d1);
    expq.push_back(pack_model());
    @(posedge clk);
    #1;
    obsq.push_back(obs);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic st0(input logic [31:0] a, d);
    cycle(1'b0, 2'b01, a, d, 32'd0, 32'd0);
  endtask

  task automatic test_reset();
    logic [117:0] e, o;
    int n = 0;
    do_reset(2);
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset[%0d]: got %h want %h", n, o, e); end
      n++;
    end
    checks++;
    if ({done, store_count, cycle_count} !== 49'd0) begin
      errors++; $display("FAIL reset_zero: got %h want 0", {done, store_count, cycle_count});
    end
  endtask

  task automatic test_pass_single();
    logic [117:0] e, o;
    int n = 0;
    st0(32'd96, 32'd123);
    st0(PA, PD);
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL pass_single[%0d]: got %h want %h", n, o, e); end
      n++;
    end
    checks++;
    if ({pass, fail, store_count} !== {1'b1, 1'b0, 16'd2}) begin
      errors++; $display("FAIL pass_single_fixed: got p=%b f=%b sc=%0d want p=1 f=0 sc=2", pass, fail, store_count);
    end
  endtask

  task automatic test_after_verdict();
    logic [117:0] e, o;
    int n = 0;
    st0(32'd300, 32'd9);
    cycle(1'b0, 2'b11, 32'd300, 32'd1, PA, 32'd0);
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL after_verdict[%0d]: got %h want %h", n, o, e); end
      n++;
    end
    checks++;
    if ({pass, fail, store_count} !== {1'b1, 1'b0, 16'd2}) begin
      errors++; $display("FAIL frozen: got p=%b f=%b sc=%0d want p=1 f=0 sc=2", pass, fail, store_count);
    end
  endtask

  task automatic test_fail_single();
    logic [117:0] e, o;
    int n = 0;
    do_reset(1);
    st0(PA, 32'd5);
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL fail_single[%0d]: got %h want %h", n, o, e); end
      n++;
    end
    checks++;
    if ({fail, fail_port, fail_adr, fail_data} !== {1'b1, 2'd0, 32'd44, 32'd5}) begin
      errors++; $display("FAIL fail_capture: got f=%b port=%0d adr=%0d data=%0d want 1/0/44/5", fail, fail_port, fail_adr, fail_data);
    end
  endtask

  task automatic test_reset_after_fail();
    logic [117:0] e, o;
    int n = 0;
    do_reset(1);
    checks++;
    if (obs !== 118'd0) begin errors++; $display("FAIL reset_after_fail: got %h want 0", obs); end
    st0(PA, PD);
    idle2();
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset_after_fail[%0d]: got %h want %h", n, o, e); end
      n++;
    end
  endtask

  task automatic idle2();
    cycle(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    cycle(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic test_two_port();
    logic [117:0] e, o;
    int n = 0;
    do_reset(1);
    cycle(1'b0, 2'b11, PA, PD, 32'd200, 32'd7);
    do_reset(1);
    cycle(1'b0, 2'b11, 32'd200, 32'd7, PA, PD);
    checks++;
    if ({fail, fail_port, fail_adr} !== {1'b1, 2'd0, 32'd200}) begin
      errors++; $display("FAIL swap_capture: got f=%b port=%0d adr=%0d want 1/0/200", fail, fail_port, fail_adr);
    end
    do_reset(1);
    cycle(1'b0, 2'b11, 32'd96, 32'd1, 32'd300, 32'hABCD);
    do_reset(1);
    cycle(1'b0, 2'b10, 32'd0, 32'd0, 32'd96, 32'd3);
    cycle(1'b0, 2'b11, 32'd96, 32'd4, PA, PD);
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL two_port[%0d]: got %h want %h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_timeout();
    logic [117:0] e, o;
    int n = 0;
    do_reset(1);
    for (int i = 0; i < TO; i++) st0(32'd96, 32'(i));
    checks++;
    if ({timeout, pass, cycle_count} !== {1'b1, 1'b0, 32'd19}) begin
      errors++; $display("FAIL timeout_fixed: got t=%b p=%b cc=%0d want 1/0/19", timeout, pass, cycle_count);
    end
    st0(PA, PD);
    st0(32'd96, 32'd0);
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL timeout[%0d]: got %h want %h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_sig_at_limit();
    logic [117:0] e, o;
    int n = 0;
    do_reset(1);
    for (int i = 0; i < TO - 1; i++) st0(32'd96, 32'd0);
    st0(PA, PD);
    checks++;
    if ({pass, timeout, cycle_count} !== {1'b1, 1'b0, 32'd19}) begin
      errors++; $display("FAIL sig_at_limit: got p=%b t=%b cc=%0d want 1/0/19", pass, timeout, cycle_count);
    end
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL sig_at_limit[%0d]: got %h want %h", n, o, e); end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    logic [117:0] e, o;
    int n = 0;
    do_reset(1);
    for (int i = 0; i < 6; i++)
      cycle(1'b0, 2'(i % 4), 32'd96, 32'(i), 32'd96, 32'(i + 1));
    do_reset(1);
    cycle(1'b0, 2'b11, 32'd96, 32'd0, 32'd96, 32'd0);
    cycle(1'b0, 2'b10, 32'd0, 32'd0, 32'd95, 32'h55);
    while (expq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL back_to_back[%0d]: got %h want %h", n, o, e); end
      n++;
    end
  endtask

  initial begin
    reset = 1'b1; mem_write = '0; data_adr = '0; write_data = '0;
    m_st = 0; m_sc = '0; m_cc = '0; m_fp = '0; m_fa = '0; m_fd = '0;
    test_reset();
    test_pass_single();
    test_after_verdict();
    test_fail_single();
    test_reset_after_fail();
    test_two_port();
    test_timeout();
    test_sig_at_limit();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/store_result_monitor.md
# store_result_monitor

Synthesizable, parametrised self-check monitor for pipelined RISC-V cores. It watches one or more data-memory store ports and latches a sticky PASS / FAIL / TIMEOUT verdict. A store of a configured signature value to a configured address is a pass. A store outside the allowed scratch window is a fail. Running past a cycle budget with no verdict is a timeout. It sits beside the core's data-memory interface in both benches and FPGA builds, and generalises the single-port, fixed-address check to N ports, a programmable signature, an allowed window, a watchdog and diagnostic capture.

## Interface
Parameters:
- NPORT, 1: number of store ports monitored (1–4).
- ADDR_W, 32: store address width.
- DATA_W, 32: store data width.
- PASS_ADDR, 44: signature address.
- PASS_DATA, 32'hFFFF_FFFD (-3): signature value.
- WIN_LO, 96: lowest allowed scratch address, inclusive.
- WIN_HI, 96: highest allowed scratch address, inclusive.
- TIMEOUT_CYC, 1000: watchdog budget in cycles; must be at least 1.

Ports:
- clk, in, 1: the single clock; all state updates on its rising edge.
- reset, in, 1: synchronous, active-high.
- mem_write, in, NPORT: per-port store strobe.
- data_adr, in, NPORT×ADDR_W: per-port store address.
- write_data, in, NPORT×DATA_W: per-port store data.
- done, out, 1: verdict latched.
- pass, out, 1: verdict is PASS.
- fail, out, 1: verdict is FAIL.
- timeout, out, 1: verdict is TIMEOUT.
- fail_port, out, 2: index of the offending port.
- fail_adr, out, ADDR_W: offending address.
- fail_data, out, DATA_W: offending data.
- store_count, out, 16: stores accepted while ARMED; saturates at 16'hFFFF.
- cycle_count, out, 32: cycles spent in ARMED.

## Operation
- States: ARMED, PASS, FAIL, TIMEOUT. Reset forces ARMED. PASS, FAIL and TIMEOUT are sticky until reset.
- Per-port classification in ARMED, only when mem_write[i]=1:
  - SIG: address equals PASS_ADDR and data equals PASS_DATA.
  - OK: address lies in [WIN_LO, WIN_HI], any data.
  - BAD: anything else, including PASS_ADDR with wrong data.
- Port arbitration: the lowest-index port with SIG or BAD decides the cycle. SIG → PASS; BAD → FAIL. Higher ports in the same cycle are ignored for the verdict.
- FAIL capture: fail_port, fail_adr and fail_data load from the deciding port on the FAIL transition. They stay 0 for PASS and TIMEOUT.
- store_count adds popcount(mem_write) each ARMED cycle, saturating. It is frozen once a verdict is latched.
- cycle_count increments each ARMED cycle. ARMED → TIMEOUT when cycle_count reaches TIMEOUT_CYC-1 and no SIG/BAD event occurs that cycle.
- Simultaneous events: a SIG/BAD verdict takes priority over timeout in the same cycle.
- X/Z on mem_write while ARMED is treated as BAD.
- Stores after a verdict are ignored.

## Timing
- Reset values: all outputs 0 and state ARMED. Reset applied mid-run or after a verdict clears everything on the next edge.
- Latency: a store sampled on edge k shows its verdict outputs, registered, after edge k. That is one cycle after the strobe.
- Exactly one of pass, fail, timeout is high whenever done=1.
- First store accepted on the first rising edge with reset=0.
- cycle_count equals TIMEOUT_CYC-1 when timeout rises.

## Configuration
- STORE_MON_REPORT_EN defined:
  - On the PASS transition, prints "Simulation succeeded" with the cycle count.
  - On the FAIL transition, prints "Simulation failed" with port, address and data.
  - On the TIMEOUT transition, prints "Simulation timeout".
  - Calls $stop one cycle after done rises.
- Not defined: pure synthesizable RTL, no system tasks, identical port behaviour.

## Structure
- Package store_mon_pkg:
  - state_e enum (ARMED, PASS, FAIL, TIMEOUT).
  - cls_e enum (NONE, OK, SIG, BAD).
  - Default constants for PASS_ADDR, PASS_DATA, WIN_LO and WIN_HI.
- Sub-module store_mon_classify: combinational per-port classifier producing cls_e, instantiated NPORT times.
- Top level holds the arbiter, FSM, counters and capture registers.

## Test plan
- NPORT=1: reset for 2 cycles, then a store to 96 followed by a store of -3 to 44 → pass=1 one cycle later, store_count=2, fail=0.
- NPORT=1: store 5 to 44 → fail=1, fail_adr=44, fail_data=5, fail_port=0.
- NPORT=2, same cycle: port0 stores -3 to 44 and port1 stores to 200 → PASS. Swap the ports → FAIL with fail_port=0, fail_adr=200.
- TIMEOUT_CYC=20, only stores to 96 → timeout=1 with cycle_count=19. A SIG store on cycle 19 instead → pass=1 and timeout=0.
- Assert reset for 1 cycle after FAIL → all outputs 0. A subsequent SIG store → pass=1.
- After PASS, a store to 300 → outputs unchanged and store_count frozen. With STORE_MON_REPORT_EN defined, exactly one message is printed.
